// File: rtl/io_bus_pkg.sv
// Shared definitions for the IO bus master: FSM state encoding, bus width defaults
// and the peripheral page map used by the downstream chip-select decode.
package io_bus_pkg;

    localparam int IO_ADDR_W = 16;
    localparam int IO_DATA_W = 16;

    localparam logic [7:0] PAGE_MULT  = 8'h67;
    localparam logic [7:0] PAGE_DIV   = 8'h68;
    localparam logic [7:0] PAGE_UART  = 8'h69;
    localparam logic [7:0] PAGE_RAM   = 8'h70;
    localparam logic [7:0] PAGE_ESP   = 8'h71;
    localparam logic [7:0] PAGE_TIMER = 8'h72;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_RESP   = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    // A zero-width strobe would never be seen by the peripherals, so it becomes one cycle.
    function automatic int clamp_strobe(input int cyc);
        return (cyc < 1) ? 1 : cyc;
    endfunction

endpackage

// File: rtl/io_strobe_timer.sv
// Loadable down-counter that sets the strobe width; last is high on the final strobe cycle.
module io_strobe_timer
    import io_bus_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             last
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/io_bus_master.sv
// Second initiator on the J1 IO bus: runs timed read/write cycles for valid/ready commands.
// Define IO_MASTER_BURST_EN for multi-beat reads within one peripheral page.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// SETUP  | address/data driven, strobes low while chip-select settles
// STROBE | io_rd or io_wr high for STROBE_CYC cycles
// RESP   | read data offered on rsp_*, waiting for rsp_ready
// GAP    | strobes low, then next beat or back to IDLE
module io_bus_master
    import io_bus_pkg::*;
#(
    parameter int ADDR_W     = IO_ADDR_W,
    parameter int DATA_W     = IO_DATA_W,
    parameter int STROBE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_last,
    output logic              io_rd,
    output logic              io_wr,
    output logic [ADDR_W-1:0] io_addr,
    output logic [DATA_W-1:0] io_dout,
    input  logic [DATA_W-1:0] io_din,
    output logic              busy
);

    localparam int STROBE_EFF = clamp_strobe(STROBE_CYC);
    localparam int CNT_W      = $clog2(STROBE_EFF + 1);

`ifdef IO_MASTER_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    state_t     state;
    logic       we_q;
    logic [3:0] beats_left;
    logic       tmr_load;
    logic       tmr_en;
    logic       strobe_last;

    assign tmr_load  = (state == ST_SETUP);
    assign tmr_en    = (state == ST_STROBE);
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    io_strobe_timer #(
        .CNT_W (CNT_W)
    ) u_strobe_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (CNT_W'(STROBE_EFF)),
        .en       (tmr_en),
        .last     (strobe_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            we_q       <= 1'b0;
            beats_left <= 4'd0;
            io_rd      <= 1'b0;
            io_wr      <= 1'b0;
            io_addr    <= '0;
            io_dout    <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_last   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        we_q       <= cmd_we;
                        io_addr    <= cmd_addr;
                        io_dout    <= cmd_wdata;
                        beats_left <= (BURST_EN && !cmd_we) ? cmd_len : 4'd0;
                        state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    io_rd <= !we_q;
                    io_wr <= we_q;
                    state <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (strobe_last) begin
                        io_rd <= 1'b0;
                        io_wr <= 1'b0;
                        if (we_q) begin
                            state <= ST_GAP;
                        end else begin
                            rsp_rdata <= io_din;
                            rsp_valid <= 1'b1;
                            rsp_last  <= (beats_left == 4'd0);
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (beats_left != 4'd0) begin
                        // only the low byte walks so the page (chip-select) stays put
                        beats_left <= beats_left - 4'd1;
                        io_addr    <= {io_addr[ADDR_W-1:8], io_addr[7:0] + 8'd1};
                        state      <= ST_SETUP;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_master.sv
// Scoreboard bench for io_bus_master: directed commands, queued expected responses.
module tb_io_bus_master;
    import io_bus_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;

    logic        cmd_valid, cmd_we, cmd_ready, rsp_valid, rsp_ready, rsp_last;
    logic        io_rd, io_wr, busy;
    logic [15:0] cmd_addr, cmd_wdata, rsp_rdata, io_addr, io_dout, io_din;
    logic [3:0]  cmd_len;

    logic        cmd_valid3, cmd_we3, cmd_ready3, rsp_valid3, rsp_ready3, rsp_last3;
    logic        io_rd3, io_wr3, busy3;
    logic [15:0] cmd_addr3, cmd_wdata3, rsp_rdata3, io_addr3, io_dout3, io_din3;
    logic [3:0]  cmd_len3;

    logic        din_by_addr;
    logic [15:0] din_val;
    assign io_din = din_by_addr ? (io_addr ^ 16'h5A5A) : din_val;

    io_bus_master #(.ADDR_W(16), .DATA_W(16), .STROBE_CYC(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
        .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din),
        .busy(busy)
    );

    io_bus_master #(.ADDR_W(16), .DATA_W(16), .STROBE_CYC(3)) dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_we(cmd_we3),
        .cmd_addr(cmd_addr3), .cmd_wdata(cmd_wdata3), .cmd_len(cmd_len3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3), .rsp_last(rsp_last3),
        .io_rd(io_rd3), .io_wr(io_wr3), .io_addr(io_addr3), .io_dout(io_dout3), .io_din(io_din3),
        .busy(busy3)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [15:0] rd_addr_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input logic [15:0] data, input logic last);
        rsp_t e;
        e.data = data;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Response monitor: pops the scoreboard whenever a response handshake is about to happen.
    always @(negedge clk) begin : mon
        rsp_t e;
        if (rst) begin
            check("strobe_exclusive", 32'(io_rd & io_wr), 0);
            if (io_rd) rd_addr_q.push_back(io_addr);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got data 0x%0h expected no response", rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_rsp_rdata", 32'(rsp_rdata), 32'(e.data));
                    check("sb_rsp_last", 32'(rsp_last), 32'(e.last));
                end
            end
        end
    end

    task automatic send(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [3:0] len);
        int n = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_len   = len;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready=0 expected 1");
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        check(name, 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_addr[$];

        cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_len = 0;
        cmd_valid3 = 0; cmd_we3 = 0; cmd_addr3 = 0; cmd_wdata3 = 0; cmd_len3 = 0;
        rsp_ready = 1; rsp_ready3 = 1;
        din_by_addr = 0; din_val = 0; io_din3 = 0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_io_rd", 32'(io_rd), 0);
        check("rst_io_wr", 32'(io_wr), 0);
        check("rst_io_addr", 32'(io_addr), 0);
        check("rst_io_dout", 32'(io_dout), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 0);
        check("rst_rsp_last", 32'(rsp_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 1);

        // 1: single write
        send(1'b1, {PAGE_MULT, 8'h02}, 16'h0005, 4'd0);
        @(negedge clk);
        check("t1_c1_io_addr", 32'(io_addr), 'h6702);
        check("t1_c1_io_dout", 32'(io_dout), 'h0005);
        check("t1_c1_io_wr", 32'(io_wr), 0);
        check("t1_c1_io_rd", 32'(io_rd), 0);
        check("t1_c1_cmd_ready", 32'(cmd_ready), 0);
        @(negedge clk);
        check("t1_c2_io_wr", 32'(io_wr), 1);
        check("t1_c2_io_rd", 32'(io_rd), 0);
        @(negedge clk);
        check("t1_c3_io_wr", 32'(io_wr), 0);
        check("t1_c3_rsp_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        check("t1_c4_cmd_ready", 32'(cmd_ready), 1);

        // 2: single read
        din_val = 16'h00A5;
        expect_rsp(16'h00A5, 1'b1);
        send(1'b0, {PAGE_UART, 8'h04}, 16'h0000, 4'd0);
        @(negedge clk);
        check("t2_c1_io_rd", 32'(io_rd), 0);
        @(negedge clk);
        check("t2_c2_io_rd", 32'(io_rd), 1);
        @(negedge clk);
        check("t2_c3_io_rd", 32'(io_rd), 0);
        check("t2_c3_rsp_valid", 32'(rsp_valid), 1);
        check("t2_c3_rsp_rdata", 32'(rsp_rdata), 'h00A5);
        check("t2_c3_rsp_last", 32'(rsp_last), 1);
        wait_idle("t2_idle");

        // 3: back-pressured response
        rsp_ready = 1'b0;
        din_val = 16'h1234;
        expect_rsp(16'h1234, 1'b1);
        send(1'b0, {PAGE_DIV, 8'h00}, 16'h0000, 4'd0);
        @(negedge clk);
        @(negedge clk);
        check("t3_c2_io_rd", 32'(io_rd), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_rsp_valid", 32'(rsp_valid), 1);
            check("t3_hold_rsp_rdata", 32'(rsp_rdata), 'h1234);
            check("t3_hold_io_rd", 32'(io_rd), 0);
            check("t3_hold_io_wr", 32'(io_wr), 0);
            check("t3_hold_cmd_ready", 32'(cmd_ready), 0);
            if (i == 0) din_val = 16'hBEEF;
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_rsp_done", 32'(rsp_valid), 0);
        wait_idle("t3_idle");

        // 4: burst read across the low-byte wrap
        din_by_addr = 1'b1;
        rd_addr_q.delete();
`ifdef IO_MASTER_BURST_EN
        exp_addr = '{16'h70FE, 16'h70FF, 16'h7000, 16'h7001};
        expect_rsp(16'h2AA4, 1'b0);
        expect_rsp(16'h2AA5, 1'b0);
        expect_rsp(16'h2A5A, 1'b0);
        expect_rsp(16'h2A5B, 1'b1);
`else
        exp_addr = '{16'h70FE};
        expect_rsp(16'h2AA4, 1'b1);
`endif
        send(1'b0, {PAGE_RAM, 8'hFE}, 16'h0000, 4'd3);
        wait_idle("t4_idle");
        check("t4_beats", 32'(rd_addr_q.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < rd_addr_q.size(); i++)
            check("t4_beat_addr", 32'(rd_addr_q[i]), 32'(exp_addr[i]));
        din_by_addr = 1'b0;

        // 5: reset during the write strobe
        send(1'b1, {PAGE_MULT, 8'h05}, 16'h0055, 4'd0);
        @(negedge clk);
        @(negedge clk);
        check("t5_c2_io_wr", 32'(io_wr), 1);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_io_wr", 32'(io_wr), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_io_addr", 32'(io_addr), 0);
        check("t5_rst_cmd_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        send(1'b1, {PAGE_TIMER, 8'h10}, 16'hCAFE, 4'd0);
        @(negedge clk);
        check("t5_c1_io_addr", 32'(io_addr), 'h7210);
        check("t5_c1_io_dout", 32'(io_dout), 'hCAFE);
        @(negedge clk);
        check("t5_c2_io_wr", 32'(io_wr), 1);
        wait_idle("t5_idle");

        // 6: three-cycle strobe, data changes each strobe cycle
        io_din3 = 16'h0001;
        @(posedge clk); #1;
        cmd_valid3 = 1'b1;
        cmd_we3    = 1'b0;
        cmd_addr3  = {PAGE_TIMER, 8'h04};
        check("t6_cmd_ready", 32'(cmd_ready3), 1);
        @(posedge clk); #1;
        cmd_valid3 = 1'b0;
        @(negedge clk);
        check("t6_c1_io_rd", 32'(io_rd3), 0);
        check("t6_c1_io_addr", 32'(io_addr3), 'h7204);
        check("t6_c1_io_dout", 32'(io_dout3), 0);
        @(negedge clk);
        check("t6_c2_io_rd", 32'(io_rd3), 1);
        @(posedge clk); #1;
        io_din3 = 16'h0002;
        @(negedge clk);
        check("t6_c3_io_rd", 32'(io_rd3), 1);
        @(posedge clk); #1;
        io_din3 = 16'h0003;
        @(negedge clk);
        check("t6_c4_io_rd", 32'(io_rd3), 1);
        check("t6_c4_io_wr", 32'(io_wr3), 0);
        @(posedge clk); #1;
        io_din3 = 16'h0009;
        @(negedge clk);
        check("t6_c5_io_rd", 32'(io_rd3), 0);
        check("t6_c5_rsp_valid", 32'(rsp_valid3), 1);
        check("t6_c5_rsp_rdata", 32'(rsp_rdata3), 'h0003);
        check("t6_c5_rsp_last", 32'(rsp_last3), 1);
        repeat (3) @(negedge clk);
        check("t6_idle", 32'(busy3), 0);

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_bus_master.md
Name: io_bus_master

Overview:
Sequencer that acts as a second initiator on the J1 peripheral IO bus (io_rd/io_wr/io_addr/io_dout/io_din). It accepts read and write commands on a valid/ready interface and performs timed bus cycles. For reads it returns the captured data on a valid/ready response channel. It lets a debug link or DMA-style engine reach the peripheral pages (mult, div, uart, RAM, espDriver, timer) without the CPU; bus arbitration is external.

Parameters:
ADDR_W, 16, IO address width (upper byte = peripheral page, decoded to chip-select downstream)
DATA_W, 16, IO data width
STROBE_CYC, 1, cycles io_rd/io_wr held high per beat; a value of 0 is clamped to 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_we  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  start address
cmd_wdata  in  DATA_W  write data
cmd_len  in  4  burst beats minus 1 (reads only, IO_MASTER_BURST_EN)
rsp_valid  out  1  read data available
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_W  captured read data
rsp_last  out  1  final beat of command
io_rd  out  1  bus read strobe
io_wr  out  1  bus write strobe
io_addr  out  ADDR_W  bus address
io_dout  out  DATA_W  bus write data
io_din  in  DATA_W  bus read data (combinational mux return)
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; io_rd, io_wr, io_addr, io_dout, rsp_valid, rsp_rdata, rsp_last and busy are all 0. cmd_ready=1, since it is decoded from IDLE.
- All io_* and rsp_* outputs are registered. io_rd and io_wr are never high together.
- The FSM has five states: IDLE, SETUP, STROBE, RESP, GAP.
- IDLE: cmd_ready=1. A handshake captures we, addr, wdata and len, then moves to SETUP.
- SETUP (1 cycle): io_addr and io_dout are driven, strobes stay low so the chip-select decode settles. Moves to STROBE.
- STROBE (STROBE_CYC cycles): io_wr or io_rd is high and the strobe counter counts down.
  - Reads: io_din is captured into rsp_rdata on the last strobe cycle.
  - Exit: read goes to RESP, write goes to GAP.
- RESP: rsp_valid=1. rsp_rdata and rsp_last are held stable until rsp_ready, then the block moves to GAP. No bus activity occurs while in RESP.
- GAP (1 cycle): strobes low, address held. Then either:
  - remaining beats > 0: move to SETUP with the next address, or
  - no beats remain: move to IDLE.
- Latency, read, STROBE_CYC=1: handshake in cycle 0, SETUP in 1, io_rd in 2, rsp_valid from cycle 3.
- Latency, write: io_wr in cycle 2, cmd_ready high again in cycle 4.
- Writes produce no response.
- cmd_ready is 0 in every state except IDLE; commands offered while busy wait.
- Reset asserted mid-operation: strobes drop immediately (asynchronously), any pending response is discarded, and the block returns to IDLE.
- rsp_last=1 on every single-beat read.

Optional Feature:
Macro IO_MASTER_BURST_EN.
- Enabled:
  - Reads perform cmd_len+1 beats.
  - Between beats, io_addr[7:0] increments and wraps 0xFF→0x00; io_addr[15:8] is held so the chip-select never changes.
  - rsp_last=1 only on the final beat.
  - Writes ignore cmd_len.
- Disabled: cmd_len is ignored, and every command is a single beat.

Decomposition:
Package io_bus_pkg holds:
- the state encoding and ADDR_W/DATA_W defaults;
- page constants PAGE_MULT=8'h67, PAGE_DIV=8'h68, PAGE_UART=8'h69, PAGE_RAM=8'h70, PAGE_ESP=8'h71, PAGE_TIMER=8'h72.

One sub-module, io_strobe_timer: a loadable down-counter that generates the strobe width and the last-cycle pulse.

Test Plan:
1. Write addr 0x6702, wdata 0x0005 (STROBE_CYC=1): cycle 1 has io_addr=0x6702, io_dout=0x0005, strobes 0; cycle 2 has io_wr=1 for one cycle; no rsp_valid; cmd_ready=1 at cycle 4.
2. Read addr 0x6904 with stub io_din=0x00A5: io_rd=1 in cycle 2 only; cycle 3 has rsp_valid=1, rsp_rdata=0x00A5, rsp_last=1.
3. Read with rsp_ready low for 5 cycles: rsp_valid and rsp_rdata stay stable, io_rd/io_wr stay 0, cmd_ready=0; the response completes the cycle after rsp_ready rises.
4. Burst read addr 0x70FE, cmd_len=3:
   - macro on: reads at 0x70FE, 0x70FF, 0x7000, 0x7001; rsp_last is set only on the 4th beat;
   - macro off: a single read at 0x70FE with rsp_last=1.
5. Assert rst during the write strobe: io_wr goes to 0 the same cycle, busy=0, no response; a command after release executes normally.
6. STROBE_CYC=3, read with io_din changing 0x0001→0x0002→0x0003 across the strobe: io_rd is high for exactly 3 cycles and rsp_rdata=0x0003.
